// File: rtl/mem_port_arbiter_if.sv
// Pipeline and memory-macro signals of the shared memory port arbiter.
// IF/MEM request channels, responses and the single memory port.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              stall_if;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  mem_rdata,
    output if_gnt, if_rvalid, if_rdata, stall_if,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, stall_if,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between IF and MEM, DM has priority.
// Define MEM_ARB_STARVE_GUARD_EN to force an IF win after STARVE_LIMIT losses.
module mem_port_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 3
) (
  input  logic               CLK,
  input  logic               RST,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_IF   = 2'd1,
    RESP_DM   = 2'd2
  } resp_e;

  resp_e             resp_q, resp_d;
  logic [DATA_W-1:0] if_hold_q, if_hold_d;
  logic [DATA_W-1:0] dm_hold_q, dm_hold_d;
  logic              if_win, dm_win;
  logic              force_if;

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("STARVE_LIMIT must be at least 1");
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign force_if = (cnt_q == CNT_MAX);

  // Count consecutive lost IF arbitrations; clear on IF win or idle IF
  always_comb begin
    cnt_d = cnt_q;
    if (!bus.if_req || if_win) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Starvation counter register
  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  // Pick the winner: DM first unless IF has been starved too long
  always_comb begin
    dm_win = bus.dm_req & ~(force_if & bus.if_req);
    if_win = bus.if_req & ~dm_win;
  end

  assign bus.dm_gnt   = dm_win;
  assign bus.if_gnt   = if_win;
  assign bus.stall_if = bus.if_req & ~if_win;

  // Drive the memory port from the granted requester
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = {ADDR_W{1'b0}};
    bus.mem_wdata = {DATA_W{1'b0}};
    unique case (1'b1)
      dm_win: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = bus.dm_we;
        bus.mem_addr  = bus.dm_addr;
        bus.mem_wdata = bus.dm_wdata;
      end
      if_win: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = bus.if_addr;
      end
      default: ;
    endcase
  end

  // Remember who owns next cycle's read data; writes need no response
  always_comb begin
    resp_d = RESP_NONE;
    if (if_win) begin
      resp_d = RESP_IF;
    end else if (dm_win && !bus.dm_we) begin
      resp_d = RESP_DM;
    end
  end

  // Pass read data to its owner; the other side keeps its last value
  always_comb begin
    if_hold_d = if_hold_q;
    dm_hold_d = dm_hold_q;
    if (resp_q == RESP_IF) begin
      if_hold_d = bus.mem_rdata;
    end
    if (resp_q == RESP_DM) begin
      dm_hold_d = bus.mem_rdata;
    end
  end

  // Response owner and held read data registers
  always_ff @(posedge CLK) begin
    if (!RST) begin
      resp_q    <= RESP_NONE;
      if_hold_q <= {DATA_W{1'b0}};
      dm_hold_q <= {DATA_W{1'b0}};
    end else begin
      resp_q    <= resp_d;
      if_hold_q <= if_hold_d;
      dm_hold_q <= dm_hold_d;
    end
  end

  assign bus.if_rvalid = (resp_q == RESP_IF);
  assign bus.dm_rvalid = (resp_q == RESP_DM);
  assign bus.if_rdata  = if_hold_d;
  assign bus.dm_rdata  = dm_hold_d;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vectors, shadow-memory model,
// per-cycle compare of every output plus literal spot checks.
module tb_mem_port_arbiter;
  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int LIM = 3;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b0;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifc ();

  mem_port_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .STARVE_LIMIT(LIM)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(ifc)
  );

  always #5 CLK = ~CLK;

  // synchronous write-first memory macro
  logic [7:0] ram [256];
  logic [7:0] mrd = 8'h00;
  assign ifc.mem_rdata = mrd;

  always @(posedge CLK) begin
    if (ifc.mem_en) begin
      if (ifc.mem_we) begin
        ram[ifc.mem_addr] <= ifc.mem_wdata;
        mrd <= ifc.mem_wdata;
      end else begin
        mrd <= ram[ifc.mem_addr];
      end
    end
  end

  int unsigned total = 0;
  int unsigned bad = 0;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // model: contents, pending response owner/data, lost IF count
  logic [7:0] shadow [256];
  bit         model_ok = 1'b0;
  int         lost = 0;
  int         pend = 0;
  logic [7:0] pdata = 8'h00;
  logic [7:0] ihold = 8'h00;
  logic [7:0] dhold = 8'h00;

  // 0 = nobody, 1 = IF, 2 = DM
  function automatic int winner();
    if (ifc.dm_req && !(GUARD && lost >= LIM && ifc.if_req)) return 2;
    if (ifc.if_req) return 1;
    return 0;
  endfunction

  always @(posedge CLK) begin
    int w;
    w = winner();
    if (w == 2 && ifc.dm_we) shadow[ifc.dm_addr] = ifc.dm_wdata;
    if (!RST) begin
      model_ok = 1'b1;
      pend = 0;
      ihold = 8'h00;
      dhold = 8'h00;
      lost = 0;
    end else begin
      if (pend == 1) ihold = pdata;
      if (pend == 2) dhold = pdata;
      pend = 0;
      if (w == 1) begin
        pend = 1;
        pdata = shadow[ifc.if_addr];
      end else if (w == 2 && !ifc.dm_we) begin
        pend = 2;
        pdata = shadow[ifc.dm_addr];
      end
      if (!ifc.if_req || w == 1) lost = 0;
      else if (lost < LIM) lost++;
    end
  end

  always @(negedge CLK) begin
    int w;
    if (model_ok) begin
      w = winner();
      chk("if_gnt", 32'(ifc.if_gnt), 32'(w == 1));
      chk("dm_gnt", 32'(ifc.dm_gnt), 32'(w == 2));
      chk("stall_if", 32'(ifc.stall_if), 32'(ifc.if_req && w != 1));
      chk("mem_en", 32'(ifc.mem_en), 32'(w != 0));
      chk("mem_we", 32'(ifc.mem_we), 32'(w == 2 && ifc.dm_we));
      chk("mem_addr", 32'(ifc.mem_addr),
          (w == 2) ? 32'(ifc.dm_addr) : (w == 1) ? 32'(ifc.if_addr) : 32'd0);
      chk("mem_wdata", 32'(ifc.mem_wdata),
          (w == 2) ? 32'(ifc.dm_wdata) : 32'd0);
      chk("if_rvalid", 32'(ifc.if_rvalid), 32'(pend == 1));
      chk("dm_rvalid", 32'(ifc.dm_rvalid), 32'(pend == 2));
      chk("if_rdata", 32'(ifc.if_rdata),
          (pend == 1) ? 32'(pdata) : 32'(ihold));
      chk("dm_rdata", 32'(ifc.dm_rdata),
          (pend == 2) ? 32'(pdata) : 32'(dhold));
    end
  end

  task automatic drv(input logic ir, input logic [7:0] ia,
                     input logic dr, input logic dw,
                     input logic [7:0] da, input logic [7:0] dd);
    ifc.if_req   = ir;
    ifc.if_addr  = ia;
    ifc.dm_req   = dr;
    ifc.dm_we    = dw;
    ifc.dm_addr  = da;
    ifc.dm_wdata = dd;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic       ir;
    logic [7:0] ia;
    logic       dr;
    logic       dw;
    logic [7:0] da;
    logic [7:0] dd;
  } vec_t;

  vec_t vecs [9];
  logic [5:0] pat;

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] <= 8'(i * 3 + 1);
      shadow[i] = 8'(i * 3 + 1);
    end
    ram[8'h10] <= 8'h3C; shadow[8'h10] = 8'h3C;
    ram[8'h05] <= 8'h11; shadow[8'h05] = 8'h11;
    ram[8'h80] <= 8'hA5; shadow[8'h80] = 8'hA5;

    vecs[0] = '{1'b1, 8'h10, 1'b1, 1'b1, 8'h30, 8'h9C};
    vecs[1] = '{1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h30, 8'h00};
    vecs[3] = '{1'b1, 8'h30, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[4] = '{1'b1, 8'h05, 1'b1, 1'b0, 8'h10, 8'h00};
    vecs[5] = '{1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h05, 8'h5E};
    vecs[7] = '{1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};

    // reset for two edges with both requests up
    RST = 1'b0;
    drv(1'b1, 8'h05, 1'b1, 1'b0, 8'h80, 8'h00);
    @(negedge CLK);
    chk("rst_dm_gnt", 32'(ifc.dm_gnt), 32'd1);
    chk("rst_if_gnt", 32'(ifc.if_gnt), 32'd0);
    tick();
    RST = 1'b1;
    drv(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge CLK);
    chk("rel_if_rvalid", 32'(ifc.if_rvalid), 32'd0);
    chk("rel_dm_rvalid", 32'(ifc.dm_rvalid), 32'd0);
    chk("rel_if_rdata", 32'(ifc.if_rdata), 32'd0);
    chk("rel_dm_rdata", 32'(ifc.dm_rdata), 32'd0);
    tick();

    // IF-only read
    drv(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge CLK);
    chk("ifrd_gnt", 32'(ifc.if_gnt), 32'd1);
    chk("ifrd_addr", 32'(ifc.mem_addr), 32'h10);
    chk("ifrd_we", 32'(ifc.mem_we), 32'd0);
    tick();
    drv(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge CLK);
    chk("ifrd_rvalid", 32'(ifc.if_rvalid), 32'd1);
    chk("ifrd_rdata", 32'(ifc.if_rdata), 32'h3C);
    chk("ifrd_dm_rvalid", 32'(ifc.dm_rvalid), 32'd0);
    tick();

    // conflict: DM read wins, IF follows
    drv(1'b1, 8'h05, 1'b1, 1'b0, 8'h80, 8'h00);
    @(negedge CLK);
    chk("cf_dm_gnt", 32'(ifc.dm_gnt), 32'd1);
    chk("cf_stall", 32'(ifc.stall_if), 32'd1);
    tick();
    drv(1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge CLK);
    chk("cf_dm_rdata", 32'(ifc.dm_rdata), 32'hA5);
    chk("cf_if_gnt", 32'(ifc.if_gnt), 32'd1);
    tick();
    drv(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge CLK);
    chk("cf_if_rdata", 32'(ifc.if_rdata), 32'h11);
    chk("cf_dm_hold", 32'(ifc.dm_rdata), 32'hA5);
    tick();

    // DM write then IF read of the same address
    drv(1'b0, 8'h00, 1'b1, 1'b1, 8'h20, 8'h7E);
    @(negedge CLK);
    chk("wr_mem_we", 32'(ifc.mem_we), 32'd1);
    tick();
    drv(1'b1, 8'h20, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge CLK);
    chk("wr_dm_rvalid", 32'(ifc.dm_rvalid), 32'd0);
    tick();
    drv(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge CLK);
    chk("wr_if_rdata", 32'(ifc.if_rdata), 32'h7E);
    tick();

    // starvation: both held for six cycles
    pat = GUARD ? 6'b110111 : 6'b111111;
    drv(1'b1, 8'h05, 1'b1, 1'b0, 8'h80, 8'h00);
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      chk("starve_dm_gnt", 32'(ifc.dm_gnt), 32'(pat[c]));
      tick();
    end
    drv(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();

    // back-to-back mixed traffic
    for (int k = 0; k < 9; k++) begin
      drv(vecs[k].ir, vecs[k].ia, vecs[k].dr,
          vecs[k].dw, vecs[k].da, vecs[k].dd);
      tick();
    end

    // reset together with an IF read grant drops the response
    drv(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 8'h00);
    RST = 1'b0;
    @(negedge CLK);
    chk("rrd_if_gnt", 32'(ifc.if_gnt), 32'd1);
    tick();
    RST = 1'b1;
    drv(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge CLK);
    chk("rrd_if_rvalid", 32'(ifc.if_rvalid), 32'd0);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
